// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op encodings (mult, multu, div, divu)
//   - FSM state enum (IDLE / RUN / FINISH)
//   - helpers for op decoding and iteration-counter sizing
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Iteration counter must hold 0..WIDTH-1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // mult and div are the signed flavours (op[0] == 0).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // div and divu have op[1] set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Purely combinational single iteration of the multiply/divide datapath.
// Operates on unsigned magnitudes only; sign handling lives in the top level.
//
// Accumulator layout (2*WIDTH bits):
//   multiply: {partial_product_hi, remaining_multiplier_bits}
//             add operand when LSB set, then shift right by one (carry kept).
//   divide:   {partial_remainder, remaining_dividend_bits / quotient_bits}
//             shift left one, trial-subtract divisor, keep or restore.
//
// Ports:
//   i_is_div   1          select divide (1) or multiply (0) step
//   i_acc      2*WIDTH    accumulator before this iteration
//   i_operand  WIDTH      multiplicand magnitude or divisor magnitude
//   o_acc      2*WIDTH    accumulator after this iteration
// -----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_operand,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_shift;
    logic [WIDTH:0] w_diff;

    always_comb begin
        // Multiply: W+1-bit add so the carry shifts into the upper half.
        w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
              + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});

        // Divide: the remainder is always below the divisor, so after the
        // left shift it fits in W+1 bits, and bit W of the difference is a
        // clean borrow flag.
        w_rem_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_diff      = w_rem_shift - {1'b0, i_operand};

        o_acc = {w_sum, i_acc[WIDTH-1:1]};
        if (i_is_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_shift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
// Latency: start sampled at edge E0, result in HI/LO with done=1 after edge
// E(WIDTH+1). busy is high in RUN and FINISH.
//
// Ports:
//   clk       in   1      system clock
//   reset     in   1      asynchronous active-high reset, clears all state
//   start     in   1      begin operation selected by op (IDLE only)
//   op        in   2      00 mult, 01 multu, 10 div, 11 divu
//   busA      in   WIDTH  multiplicand / dividend; data for mthi/mtlo
//   busB      in   WIDTH  multiplier / divisor
//   write_hi  in   1      mthi: HI <= busA (IDLE, no start)
//   write_lo  in   1      mtlo: LO <= busA (IDLE, no start)
//   busy      out  1      operation in progress
//   done      out  1      single-cycle pulse when HI/LO take a result
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             write_hi,
    input  logic             write_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // FSM
    state_t r_state;
    state_t w_state_next;
    logic   r_busy;
    logic   r_done;
    logic   w_busy_next;
    logic   w_done_next;

    // Datapath state
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_busa;
    logic               r_is_div;
    logic               r_neg_result;  // operand signs differ on a signed op
    logic               r_neg_rem;     // signed dividend was negative
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand conditioning at start
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    // Iteration and result fix-up
    logic [2*WIDTH-1:0] w_step_acc;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_hi_result;
    logic [WIDTH-1:0]   w_lo_result;

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // -------------------------------------------------------------------------
    // Operand conditioning: signed ops iterate on magnitudes. The magnitude of
    // the most negative value is representable as an unsigned WIDTH-bit value.
    // -------------------------------------------------------------------------
    always_comb begin
        w_signed = op_is_signed(op);
        w_sign_a = w_signed & busA[WIDTH-1];
        w_sign_b = w_signed & busB[WIDTH-1];
        w_mag_a  = w_sign_a ? (-busA) : busA;
        w_mag_b  = w_sign_b ? (-busB) : busB;
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_is_div  (r_is_div),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_step_acc)
    );

    // -------------------------------------------------------------------------
    // Sign fix-up and divide-by-zero override applied in FINISH.
    // -------------------------------------------------------------------------
    always_comb begin
        w_prod_fix = r_neg_result ? (-r_acc) : r_acc;
        w_quot_fix = r_neg_result ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
        w_rem_fix  = r_neg_rem ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

        if (!r_is_div) begin
            w_hi_result = w_prod_fix[2*WIDTH-1:WIDTH];
            w_lo_result = w_prod_fix[WIDTH-1:0];
        end else if (r_div_zero) begin
            w_hi_result = r_busa;
            w_lo_result = {WIDTH{1'b1}};
        end else begin
            w_hi_result = w_rem_fix;
            w_lo_result = w_quot_fix;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state and registered status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_count == CNT_LAST) w_state_next = FINISH;
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM: outputs (registered above so busy/done come straight from flops)
    always_comb begin
        w_busy_next = (w_state_next != IDLE);
        w_done_next = (r_state == FINISH);
    end

    // -------------------------------------------------------------------------
    // Datapath and HI/LO. HI/LO only change on mthi/mtlo in IDLE or in FINISH,
    // so no partial results ever appear on the outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_acc        <= '0;
            r_operand    <= '0;
            r_busa       <= '0;
            r_is_div     <= 1'b0;
            r_neg_result <= 1'b0;
            r_neg_rem    <= 1'b0;
            r_div_zero   <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (start) begin
                        // start takes priority; a simultaneous mthi/mtlo is dropped
                        r_is_div     <= op_is_div(op);
                        r_busa       <= busA;
                        r_neg_result <= w_sign_a ^ w_sign_b;
                        r_neg_rem    <= w_sign_a;
                        r_div_zero   <= op_is_div(op) && (busB == '0);
                        if (op_is_div(op)) begin
                            r_operand <= w_mag_b;
                            r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
                        end else begin
                            r_operand <= w_mag_a;
                            r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
                        end
                    end else begin
                        if (write_hi) r_hi <= busA;
                        if (write_lo) r_lo <= busA;
                    end
                end
                RUN: begin
                    r_acc   <= w_step_acc;
                    r_count <= r_count + CNT_ONE;
                end
                FINISH: begin
                    r_hi    <= w_hi_result;
                    r_lo    <= w_lo_result;
                    r_count <= '0;
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors with hand-computed results. Operation results go through a
// scoreboard queue that a separate monitor drains on every done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] busA = '0;
    logic [31:0] busB = '0;
    logic        write_hi = 1'b0;
    logic        write_lo = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .busA     (busA),
        .busB     (busB),
        .write_hi (write_hi),
        .write_lo (write_lo),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {31'b0, done}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                    $display("result %s: hi=%h lo=%h", e.name, hi, lo);
                end
            end
        end
    end

    // Drive a start for one cycle; returns at the first negedge after the
    // sampling edge with start already deasserted.
    task automatic start_op(input string name, input logic [1:0] o,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el,
                            input bit push);
        exp_t e;
        @(negedge clk);
        op = o; busA = a; busB = b; start = 1'b1;
        if (push) begin
            e.name = name; e.hi = eh; e.lo = el;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy samples (already = samples consumed by the caller), then
    // check latency and the single-cycle done pulse.
    task automatic wait_done(input string name, input int already);
        int cycles;
        cycles = already;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(cycles), 32'd33);
        check({name, "_done_pulse"}, {31'b0, done}, 32'd1);
        @(negedge clk);
        check({name, "_done_low"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"multu_ffff_x2",  MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[1] = '{"mult_m3_x5",     MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{"div_m7_d2",      DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"divu_7_d0",      DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
        vecs[4] = '{"div_7_dm2",      DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[5] = '{"div_min_dm1",    DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{"div_m7_d0",      DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{"mult_min_min",   MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{"multu_max_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[9] = '{"divu_max_d16",   DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hi",   hi,              32'd0);
        check("rst_lo",   lo,              32'd0);
        check("rst_busy", {31'b0, busy},   32'd0);
        check("rst_done", {31'b0, done},   32'd0);
        reset = 1'b0;
        $display("reset released");

        // mtlo in IDLE
        @(negedge clk);
        busA = 32'h12345678; write_lo = 1'b1;
        @(negedge clk);
        write_lo = 1'b0;
        check("mtlo_lo",   lo,            32'h12345678);
        check("mtlo_hi",   hi,            32'd0);
        check("mtlo_done", {31'b0, done}, 32'd0);
        $display("mtlo: lo=%h", lo);

        // mthi + mtlo together
        busA = 32'hA5A5A5A5; write_hi = 1'b1; write_lo = 1'b1;
        @(negedge clk);
        write_hi = 1'b0; write_lo = 1'b0;
        check("mthilo_hi", hi, 32'hA5A5A5A5);
        check("mthilo_lo", lo, 32'hA5A5A5A5);
        $display("mthi+mtlo: hi=%h lo=%h", hi, lo);

        // start and mthi in the same cycle: write dropped
        write_hi = 1'b1;
        start_op("multu_3x4_wr", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
        write_hi = 1'b0;
        check("start_wr_hi_dropped", hi, 32'hA5A5A5A5);
        wait_done("multu_3x4_wr", 0);

        // mthi while busy: ignored, latched operands undisturbed
        start_op("multu_64k_sq", MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b1);
        busA = 32'hDEADBEEF; busB = 32'h0; write_hi = 1'b1;
        @(negedge clk);
        write_hi = 1'b0;
        check("busy_mthi_hi", hi, 32'd0);
        check("busy_lo_hold", lo, 32'd12);
        wait_done("multu_64k_sq", 1);

        // Directed vector table
        foreach (vecs[i]) begin
            start_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
            wait_done(vecs[i].name, 0);
        end

        // Second start during RUN ignored
        start_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        repeat (4) @(negedge clk);
        busA = 32'd1; busB = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("divu_100_7", 5);

        // Reset mid-RUN: immediate clear, no done
        start_op("mult_abort", MULT, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_hi",   hi,            32'd0);
        check("abort_lo",   lo,            32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        $display("reset mid-run: hi=%h lo=%h busy=%b", hi, lo, busy);
        @(negedge clk);
        reset = 1'b0;

        start_op("mult_6x7", MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);
        wait_done("mult_6x7", 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
